// File: rtl/automatic_washing_machine.sv
`default_nettype none
// ============================================================================
//  Module      : automatic_washing_machine
//  Description : Top-level sequencing FSM for a front-loading washing machine.
//                Runs fill -> detergent -> wash -> drain -> rinse fill ->
//                rinse -> drain -> spin -> done.
//                Inputs are level flags from external level sensors and
//                timers. Outputs are actuator enables, Moore-decoded from the
//                state register and the rinse-pass flag.
//  Ports       : reset           async active-high, forces IDLE
//                clk             system clock, rising edge
//                door_close      door physically closed
//                start           user start request (level)
//                water_filled    drum at fill level
//                detergent_added detergent dispensed
//                cycle_timeout   wash/rinse agitation timer expired
//                drained         drum empty
//                spin_timeout    spin timer expired
//                door_lock, fill_value_on, soap_wash, motor_on,
//                drain_value_on, water_wash   actuator enables
//                done            one-clock cycle-complete pulse
//  Config      : `define DOOR_ABORT_EN adds an ABORT state. Opening the door in
//                FILL/DETERGENT/WASH/SPIN drains the drum and returns to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module automatic_washing_machine (
    input  logic reset,
    input  logic clk,
    input  logic door_close,
    input  logic start,
    input  logic water_filled,
    input  logic detergent_added,
    input  logic cycle_timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic fill_value_on,
    output logic soap_wash,
    output logic motor_on,
    output logic drain_value_on,
    output logic water_wash,
    output logic done
);

    // Binary state encoding. The ABORT code is reserved even when the abort
    // feature is compiled out, so the encoding stays the same in both builds.
    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FILL      = 3'd1;
    localparam logic [2:0] c_S_DETERGENT = 3'd2;
    localparam logic [2:0] c_S_WASH      = 3'd3;
    localparam logic [2:0] c_S_DRAIN     = 3'd4;
    localparam logic [2:0] c_S_SPIN      = 3'd5;
    localparam logic [2:0] c_S_DONE      = 3'd6;
    localparam logic [2:0] c_S_ABORT     = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    // r_rinse distinguishes the second (rinse) pass through FILL/WASH/DRAIN
    // from the first (soap) pass.
    logic       r_rinse;
    logic       w_next_rinse;
    logic       w_door_open;

    assign w_door_open = ~door_close;

    // ------------------------------------------------------------------------
    // State and rinse-flag registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_rinse <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rinse <= w_next_rinse;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_rinse = r_rinse;
        case (r_state)
            c_S_IDLE: begin
                // A start request with the door open is ignored.
                if (start && door_close) begin
                    w_next_state = c_S_FILL;
                    w_next_rinse = 1'b0;
                end
            end
            c_S_FILL: begin
`ifdef DOOR_ABORT_EN
                if (w_door_open) begin
                    w_next_state = c_S_ABORT;
                end else
`endif
                if (water_filled) begin
                    w_next_state = r_rinse ? c_S_WASH : c_S_DETERGENT;
                end
            end
            c_S_DETERGENT: begin
`ifdef DOOR_ABORT_EN
                if (w_door_open) begin
                    w_next_state = c_S_ABORT;
                end else
`endif
                if (detergent_added) begin
                    w_next_state = c_S_WASH;
                end
            end
            c_S_WASH: begin
`ifdef DOOR_ABORT_EN
                if (w_door_open) begin
                    w_next_state = c_S_ABORT;
                end else
`endif
                if (cycle_timeout) begin
                    w_next_state = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                // Draining always runs to completion, even with the door
                // open, since the drum is already emptying.
                if (drained) begin
                    if (r_rinse) begin
                        w_next_state = c_S_SPIN;
                    end else begin
                        w_next_state = c_S_FILL;
                        w_next_rinse = 1'b1;
                    end
                end
            end
            c_S_SPIN: begin
`ifdef DOOR_ABORT_EN
                if (w_door_open) begin
                    w_next_state = c_S_ABORT;
                end else
`endif
                if (spin_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_IDLE;
            end
`ifdef DOOR_ABORT_EN
            c_S_ABORT: begin
                if (drained) begin
                    w_next_state = c_S_IDLE;
                end
            end
`endif
            default: begin
                // Unreachable codes recover to a safe idle state.
                w_next_state = c_S_IDLE;
                w_next_rinse = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode. Because the outputs depend only on registered
    // state, asserting reset clears them immediately, with no clock edge.
    // ------------------------------------------------------------------------
    always_comb begin
        door_lock      = 1'b0;
        fill_value_on  = 1'b0;
        soap_wash      = 1'b0;
        motor_on       = 1'b0;
        drain_value_on = 1'b0;
        water_wash     = 1'b0;
        done           = 1'b0;
        case (r_state)
            c_S_FILL: begin
                door_lock     = 1'b1;
                fill_value_on = 1'b1;
                water_wash    = r_rinse;
            end
            c_S_DETERGENT: begin
                door_lock = 1'b1;
                soap_wash = 1'b1;
            end
            c_S_WASH: begin
                door_lock  = 1'b1;
                motor_on   = 1'b1;
                soap_wash  = ~r_rinse;
                water_wash = r_rinse;
            end
            c_S_DRAIN: begin
                door_lock      = 1'b1;
                drain_value_on = 1'b1;
                soap_wash      = ~r_rinse;
                water_wash     = r_rinse;
            end
            c_S_SPIN: begin
                door_lock      = 1'b1;
                motor_on       = 1'b1;
                drain_value_on = 1'b1;
            end
            c_S_DONE: begin
                done = 1'b1;
            end
`ifdef DOOR_ABORT_EN
            c_S_ABORT: begin
                door_lock      = 1'b1;
                drain_value_on = 1'b1;
            end
`endif
            default: begin
                // IDLE and unused codes: everything off.
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_automatic_washing_machine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_automatic_washing_machine
//  Description : Scoreboard bench for automatic_washing_machine. Stimulus
//                pushes the expected output vector for each step into a
//                queue. A monitor pops and compares after every clock edge
//                or reset assertion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_automatic_washing_machine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic door_close = 1'b0, start = 1'b0, water_filled = 1'b0;
    logic detergent_added = 1'b0, cycle_timeout = 1'b0, drained = 1'b0;
    logic spin_timeout = 1'b0;
    logic door_lock, fill_value_on, soap_wash, motor_on;
    logic drain_value_on, water_wash, done;

    automatic_washing_machine dut (
        .reset          (reset),
        .clk            (clk),
        .door_close     (door_close),
        .start          (start),
        .water_filled   (water_filled),
        .detergent_added(detergent_added),
        .cycle_timeout  (cycle_timeout),
        .drained        (drained),
        .spin_timeout   (spin_timeout),
        .door_lock      (door_lock),
        .fill_value_on  (fill_value_on),
        .soap_wash      (soap_wash),
        .motor_on       (motor_on),
        .drain_value_on (drain_value_on),
        .water_wash     (water_wash),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Output vector: {door_lock, fill, soap, motor, drain, water_wash, done}
    localparam logic [6:0] O_IDLE   = 7'b000_0000;
    localparam logic [6:0] O_FILL0  = 7'b110_0000;
    localparam logic [6:0] O_FILL1  = 7'b110_0010;
    localparam logic [6:0] O_DET    = 7'b101_0000;
    localparam logic [6:0] O_WASH0  = 7'b101_1000;
    localparam logic [6:0] O_WASH1  = 7'b100_1010;
    localparam logic [6:0] O_DRAIN0 = 7'b101_0100;
    localparam logic [6:0] O_DRAIN1 = 7'b100_0110;
    localparam logic [6:0] O_SPIN   = 7'b100_1100;
    localparam logic [6:0] O_DONE   = 7'b000_0001;
    localparam logic [6:0] O_ABORT  = 7'b100_0100;

    // Input vector: {door_close, start, water_filled, detergent_added,
    //                cycle_timeout, drained, spin_timeout}
    localparam logic [6:0] I_NONE  = 7'b000_0000;
    localparam logic [6:0] I_DOOR  = 7'b100_0000;
    localparam logic [6:0] I_START = 7'b110_0000;
    localparam logic [6:0] I_WF    = 7'b101_0000;
    localparam logic [6:0] I_DET   = 7'b100_1000;
    localparam logic [6:0] I_CT    = 7'b100_0100;
    localparam logic [6:0] I_DR    = 7'b100_0010;
    localparam logic [6:0] I_SPIN  = 7'b100_0001;
    localparam logic [6:0] I_ALL   = 7'b111_1111;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] outs();
        return {door_lock, fill_value_on, soap_wash, motor_on,
                drain_value_on, water_wash, done};
    endfunction

    // Monitor: runs after every clock edge and every reset assertion.
    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            act = outs();
            checks++;
            if (fill_value_on && drain_value_on) begin
                errors++;
                $display("FAIL valves_exclusive: fill=%b drain=%b, required not both 1",
                         fill_value_on, drain_value_on);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: outputs=%b required=%b (lock,fill,soap,motor,drain,water,done)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    task automatic drive(input logic [6:0] iv);
        {door_close, start, water_filled, detergent_added,
         cycle_timeout, drained, spin_timeout} = iv;
    endtask

    // Drive inputs for the coming clock edge and expect exp after it.
    task automatic step(input logic [6:0] iv, input logic [6:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        drive(iv);
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(I_NONE);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stimulus
        exp_t e;
        // Reset state, checked on a clock edge with reset held.
        @(negedge clk);
        e.exp = O_IDLE; e.name = "reset_state";
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b0;

        // Test 2: start with the door open is ignored.
        for (int i = 0; i < 3; i++) step(7'b010_0000, O_IDLE, "start_door_open");

        // Test 3: full cycle with one-clock pulses, plus a hold step.
        step(I_START, O_FILL0,  "t3_fill");
        step(I_DOOR,  O_FILL0,  "t3_fill_hold");
        step(I_WF,    O_DET,    "t3_detergent");
        step(I_DOOR,  O_DET,    "t3_det_hold");
        step(I_DET,   O_WASH0,  "t3_wash");
        step(I_CT,    O_DRAIN0, "t3_drain");
        step(I_DR,    O_FILL1,  "t3_rinse_fill");
        step(I_WF,    O_WASH1,  "t3_rinse");
        step(I_CT,    O_DRAIN1, "t3_rinse_drain");
        step(I_DR,    O_SPIN,   "t3_spin");
        step(I_SPIN,  O_DONE,   "t3_done");
        step(I_DOOR,  O_IDLE,   "t3_back_idle");
        step(I_DOOR,  O_IDLE,   "t3_idle_hold");

        // Test 4: everything held high from reset release.
        apply_reset();
        step(I_ALL, O_FILL0,  "t4_c1_fill");
        step(I_ALL, O_DET,    "t4_c2_det");
        step(I_ALL, O_WASH0,  "t4_c3_wash");
        step(I_ALL, O_DRAIN0, "t4_c4_drain");
        step(I_ALL, O_FILL1,  "t4_c5_fill");
        step(I_ALL, O_WASH1,  "t4_c6_wash");
        step(I_ALL, O_DRAIN1, "t4_c7_drain");
        step(I_ALL, O_SPIN,   "t4_c8_spin");
        step(I_ALL, O_DONE,   "t4_c9_done");
        step(I_ALL, O_IDLE,   "t4_idle");
        step(I_ALL, O_FILL0,  "t4_restart");

        // Test 5: FILL holds while the water level is not reached.
        apply_reset();
        step(I_START, O_FILL0, "t5_fill");
        for (int i = 0; i < 20; i++) step(I_DOOR, O_FILL0, "t5_fill_hold");

        // Test 1: async reset from WASH clears outputs without a clock.
        apply_reset();
        step(I_START, O_FILL0, "t1_fill");
        step(I_WF,    O_DET,   "t1_det");
        step(I_DET,   O_WASH0, "t1_wash");
        @(negedge clk);
        drive(I_DOOR);
        e.exp = O_IDLE; e.name = "t1_async_reset";
        exp_q.push_back(e);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(I_NONE, O_IDLE, "t1_after_release");
        step(I_NONE, O_IDLE, "t1_stays_idle");

        // Test 6: door opened during WASH.
        step(I_START, O_FILL0, "t6_fill");
        step(I_WF,    O_DET,   "t6_det");
        step(I_DET,   O_WASH0, "t6_wash");
`ifdef DOOR_ABORT_EN
        step(I_NONE,     O_ABORT, "t6_abort");
        step(I_NONE,     O_ABORT, "t6_abort_hold");
        step(7'b000_0010, O_IDLE, "t6_abort_idle");
`else
        step(I_NONE,     O_WASH0,  "t6_wash_hold");
        step(I_NONE,     O_WASH0,  "t6_wash_hold2");
        step(7'b000_0100, O_DRAIN0, "t6_drain");
`endif

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
